seri_sifre_cozucu: RTL and testbench
====================================

# seri_sifre_cozucu

Serial receive end of the encryption link. It consumes the `bit_girisi`/`gecerli_giris` stream that the encryption chain produces, LSB first, and reassembles it into `BIT`-bit words. Each word goes through the transform chosen by `secim`: the inverse transform when `mod`=1, the forward transform when `mod`=0. The result appears as a parallel word with a one-cycle `hazir` pulse. An inter-bit gap watchdog discards stalled partial words and reports them on `hata`.

## Interface
- `BIT`, 4: word width; must be ≥2.
- `ANAHTAR`, 10: key for the XOR and add/subtract transforms; must fit in `BIT` bits.
- `saat`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `bit_girisi`  in  1  serial data bit.
- `gecerli_giris`  in  1  `bit_girisi` is valid this cycle.
- `mod`  in  1  1 = inverse (decrypt), 0 = forward (encrypt).
- `secim`  in  3  transform select.
- `veri_cikisi`  out  BIT  reassembled, transformed word.
- `hazir`  out  1  one-cycle pulse: `veri_cikisi` is new.
- `hata`  out  1  one-cycle pulse: partial word dropped on timeout.

## Operation
- **Reset values:** `veri_cikisi`=0, `hazir`=0, `hata`=0, state BOS, bit counter `sayac`=0, gap counter=0, shift register=0.
- **State BOS (idle):**
  - On the first edge with `gecerli_giris`=1: store the bit at index 0, set `sayac`=1, go to TOPLA.
  - On that same edge, latch `mod` and `secim` for the whole word. Later changes to either have no effect until the next word.
- **State TOPLA (collecting):**
  - Each edge with `gecerli_giris`=1 stores `bit_girisi` at index `sayac`, increments `sayac`, and clears the gap counter.
  - When the bit at index `BIT`-1 is stored: send the word to the output stage, set `sayac`=0, return to BOS.
- **Output stage:** on the edge after the last bit, `veri_cikisi` takes the transformed word and `hazir` is 1 for exactly one cycle. `veri_cikisi` holds its value until the next word completes.
- **Transforms** (forward / inverse; `w` = received word; all arithmetic mod 2^BIT):
  - 0: identity / identity.
  - 1: bitwise NOT / bitwise NOT.
  - 2: rotate left 1 / rotate right 1.
  - 3: bit-order reverse / bit-order reverse.
  - 4: `w` XOR `ANAHTAR` / same.
  - 5: `w`+`ANAHTAR` / `w`−`ANAHTAR`.
  - 6: rotate left floor(BIT/2) / rotate right floor(BIT/2).
  - 7: binary-to-Gray (`w`^(`w`>>1)) / Gray-to-binary (prefix XOR from the MSB down).
- **Gap watchdog:**
  - In TOPLA, each cycle with `gecerli_giris`=0 increments the gap counter.
  - On the edge ending the 2*BIT-th consecutive idle cycle: discard the partial word, set `sayac`=0, go to BOS. `hata`=1 for the next cycle only.
  - `veri_cikisi` is unchanged and `hazir` is not asserted.
- **Back-to-back words:** a valid bit on the edge that completes a word begins nothing extra, because BOS is entered afterwards. A valid bit on the very next edge is taken as bit 0 of the next word, with a new latch of `mod`/`secim`. No bubble is needed between words.
- **Reset mid-word:** any partial word is discarded and all outputs return to reset values on that edge. `hata` is not raised.
- **No validity on BOS:** the watchdog does not run in BOS.

## Timing
- **Latency:** the last bit is sampled at edge N; `hazir`=1 and the new `veri_cikisi` are visible in the cycle after edge N+1 (one registered stage).
- **Throughput:** one word per `BIT` cycles with `gecerli_giris` continuously high.
- **Output pulse spacing:** `hazir` pulses are ≥`BIT` cycles apart. `hata` and `hazir` never assert in the same cycle.
- **Gap limit:** a gap of 2*BIT−1 idle cycles is tolerated; 2*BIT idle cycles trigger a timeout.

## Test plan
- **Rotate, inverse (BIT=4):** `secim`=2, `mod`=1, bits 1,0,1,1 on 4 consecutive cycles. The received word is 4'b1101, so `veri_cikisi`=4'b1110 with a single `hazir` pulse, 1 cycle after the last bit.
- **Subtract key:** `secim`=5, `mod`=1, `ANAHTAR`=10, bits 1,1,0,0 (word 3). `veri_cikisi`=4'b1001 (3−10 mod 16).
- **Gray-to-binary and back-to-back:**
  - First word: `secim`=7, `mod`=1, bits 0,1,1,0 (Gray 4'b0110). Output 4'b0100.
  - Second word, immediately after with no gap: `secim`=1, `mod`=0, bits 0,0,0,0. Output 4'b1111.
  - `hazir` pulses exactly 4 cycles apart.
- **Gap handling:**
  - 2 valid bits, then 7 idle cycles, then 2 more bits: the word completes normally and `hata` stays 0.
  - 2 valid bits, then 8 idle cycles: one `hata` pulse and no `hazir`. The next 4 bits form a fresh word.
- **Latching:** change `secim`/`mod` after bit 0 of a word. The output uses the values latched at bit 0.
- **Reset mid-word:** 2 valid bits, then 1 cycle of `reset`. All outputs are 0 and `hata` stays 0. A following full word decodes correctly with no carry-over from the discarded bits.

Source files
------------

// File: rtl/seri_sifre_cozucu.sv
// Serial LSB-first word receiver with a per-word selectable forward/inverse transform
// and an inter-bit gap watchdog that drops stalled partial words.
module seri_sifre_cozucu #(
   parameter int BIT     = 4,
   parameter int ANAHTAR = 10
) (
   input  logic           saat,
   input  logic           reset,
   input  logic           bit_girisi,
   input  logic           gecerli_giris,
   input  logic           mod,
   input  logic [2:0]     secim,
   output logic [BIT-1:0] veri_cikisi,
   output logic           hazir,
   output logic           hata
);

   localparam int SW    = (BIT > 2) ? $clog2(BIT) : 1;
   localparam int GW    = $clog2(2 * BIT);
   localparam int YARIM = BIT / 2;
   localparam logic [SW-1:0]  SAYAC_BIR    = SW'(1);
   localparam logic [SW-1:0]  SON_BIT      = SW'(BIT - 1);
   localparam logic [GW-1:0]  BOSLUK_BIR   = GW'(1);
   localparam logic [GW-1:0]  BOSLUK_SINIR = GW'(2 * BIT - 1);
   localparam logic [BIT-1:0] ANAHTAR_W    = BIT'(ANAHTAR);

   typedef enum logic {BOS, TOPLA} durum_t;

   durum_t         durum_q, durum_d;
   logic [SW-1:0]  sayac_q, sayac_d;
   logic [GW-1:0]  bosluk_q, bosluk_d;
   logic [BIT-1:0] kaydirma_q, kaydirma_d;
   logic           mod_q, mod_d;
   logic [2:0]     secim_q, secim_d;
   logic [BIT-1:0] sonuc_q, sonuc_d;
   logic           tamam_q, tamam_d;
   logic [BIT-1:0] veri_q;
   logic           hazir_q, hata_q, hata_d;
   logic [BIT-1:0] kelime_d;

   always_ff @(posedge saat) begin
      if (reset) begin
         durum_q    <= BOS;
         sayac_q    <= '0;
         bosluk_q   <= '0;
         kaydirma_q <= '0;
         mod_q      <= 1'b0;
         secim_q    <= '0;
         sonuc_q    <= '0;
         tamam_q    <= 1'b0;
         veri_q     <= '0;
         hazir_q    <= 1'b0;
         hata_q     <= 1'b0;
      end else begin
         durum_q    <= durum_d;
         sayac_q    <= sayac_d;
         bosluk_q   <= bosluk_d;
         kaydirma_q <= kaydirma_d;
         mod_q      <= mod_d;
         secim_q    <= secim_d;
         tamam_q    <= tamam_d;
         hazir_q    <= tamam_q;
         hata_q     <= hata_d;
         if (tamam_d) sonuc_q <= sonuc_d;
         if (tamam_q) veri_q  <= sonuc_q;
      end
   end

   // mod/secim are captured with bit 0 so the whole word uses one transform
   always_comb begin
      durum_d    = durum_q;
      sayac_d    = sayac_q;
      bosluk_d   = bosluk_q;
      kaydirma_d = kaydirma_q;
      mod_d      = mod_q;
      secim_d    = secim_q;
      tamam_d    = 1'b0;
      hata_d     = 1'b0;
      case (durum_q)
         BOS: begin
            bosluk_d = '0;
            if (gecerli_giris) begin
               kaydirma_d    = '0;
               kaydirma_d[0] = bit_girisi;
               sayac_d       = SAYAC_BIR;
               mod_d         = mod;
               secim_d       = secim;
               durum_d       = TOPLA;
            end
         end
         TOPLA: begin
            if (gecerli_giris) begin
               kaydirma_d[sayac_q] = bit_girisi;
               bosluk_d            = '0;
               if (sayac_q == SON_BIT) begin
                  tamam_d = 1'b1;
                  sayac_d = '0;
                  durum_d = BOS;
               end else begin
                  sayac_d = sayac_q + SAYAC_BIR;
               end
            end else if (bosluk_q == BOSLUK_SINIR) begin
               hata_d     = 1'b1;
               sayac_d    = '0;
               bosluk_d   = '0;
               kaydirma_d = '0;
               durum_d    = BOS;
            end else begin
               bosluk_d = bosluk_q + BOSLUK_BIR;
            end
         end
         default: durum_d = BOS;
      endcase
      kelime_d = kaydirma_d;
   end

   logic [BIT-1:0] ters_w, gray_geri;

   for (genvar gi = 0; gi < BIT; gi++) begin : g_bit
      assign ters_w[gi]    = kelime_d[BIT-1-gi];
      assign gray_geri[gi] = ^kelime_d[BIT-1:gi];
   end

   always_comb begin
      sonuc_d = kelime_d;
      case (secim_q)
         3'd0: sonuc_d = kelime_d;
         3'd1: sonuc_d = ~kelime_d;
         3'd2: sonuc_d = mod_q ? {kelime_d[0], kelime_d[BIT-1:1]}
                               : {kelime_d[BIT-2:0], kelime_d[BIT-1]};
         3'd3: sonuc_d = ters_w;
         3'd4: sonuc_d = kelime_d ^ ANAHTAR_W;
         3'd5: sonuc_d = mod_q ? (kelime_d - ANAHTAR_W) : (kelime_d + ANAHTAR_W);
         3'd6: sonuc_d = mod_q ? ((kelime_d >> YARIM) | (kelime_d << (BIT - YARIM)))
                               : ((kelime_d << YARIM) | (kelime_d >> (BIT - YARIM)));
         3'd7: sonuc_d = mod_q ? gray_geri : (kelime_d ^ (kelime_d >> 1));
         default: sonuc_d = kelime_d;
      endcase
   end

   assign veri_cikisi = veri_q;
   assign hazir       = hazir_q;
   assign hata        = hata_q;

endmodule

// File: tb/tb_seri_sifre_cozucu.sv
// Directed bench for seri_sifre_cozucu (BIT=4, ANAHTAR=10): one task per scenario.
module tb_seri_sifre_cozucu;

   logic       saat = 1'b0;
   logic       reset;
   logic       bit_girisi;
   logic       gecerli_giris;
   logic       mod;
   logic [2:0] secim;
   logic [3:0] veri_cikisi;
   logic       hazir;
   logic       hata;

   int testler = 0;
   int hatalar = 0;
   int hazir_sayisi = 0;
   int hata_sayisi = 0;

   seri_sifre_cozucu #(.BIT(4), .ANAHTAR(10)) dut (
      .saat          (saat),
      .reset         (reset),
      .bit_girisi    (bit_girisi),
      .gecerli_giris (gecerli_giris),
      .mod           (mod),
      .secim         (secim),
      .veri_cikisi   (veri_cikisi),
      .hazir         (hazir),
      .hata          (hata)
   );

   always #5 saat = ~saat;

   always @(negedge saat) begin
      if (hazir === 1'b1) hazir_sayisi++;
      if (hata === 1'b1) hata_sayisi++;
   end

   task automatic tick();
      @(posedge saat);
      #1;
   endtask

   task automatic bit_ver(input logic b);
      gecerli_giris = 1'b1;
      bit_girisi    = b;
      tick();
   endtask

   task automatic bos_ver(input int n);
      gecerli_giris = 1'b0;
      bit_girisi    = 1'b0;
      repeat (n) tick();
   endtask

   // Ends right after the edge following the last bit, where hazir should be high.
   task automatic kelime_gonder(input logic [3:0] w, input logic [2:0] s, input logic m);
      secim = s;
      mod   = m;
      for (int i = 0; i < 4; i++) bit_ver(w[i]);
      bos_ver(1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      gecerli_giris = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      testler++;
      if (veri_cikisi !== 4'b0000) begin
         hatalar++;
         $display("FAIL reset_veri: got %b expected 0000", veri_cikisi);
      end
      testler++;
      if (hazir !== 1'b0) begin
         hatalar++;
         $display("FAIL reset_hazir: got %b expected 0", hazir);
      end
      testler++;
      if (hata !== 1'b0) begin
         hatalar++;
         $display("FAIL reset_hata: got %b expected 0", hata);
      end
      $display("[TB] reset: veri=%b hazir=%b hata=%b", veri_cikisi, hazir, hata);
   endtask

   task automatic test_rotate_inverse();
      secim = 3'd2;
      mod   = 1'b1;
      bit_ver(1'b1);
      bit_ver(1'b0);
      bit_ver(1'b1);
      bit_ver(1'b1);
      gecerli_giris = 1'b0;
      testler++;
      if (hazir !== 1'b0) begin
         hatalar++;
         $display("FAIL rot_inv_early: hazir=%b expected 0 on last-bit edge", hazir);
      end
      tick();
      testler++;
      if (hazir !== 1'b1 || veri_cikisi !== 4'b1110) begin
         hatalar++;
         $display("FAIL rot_inv: hazir=%b veri=%b expected 1/1110", hazir, veri_cikisi);
      end
      tick();
      testler++;
      if (hazir !== 1'b0) begin
         hatalar++;
         $display("FAIL rot_inv_pulse: hazir=%b expected 0", hazir);
      end
      $display("[TB] rotate inverse: veri=%b", veri_cikisi);
   endtask

   task automatic test_subtract();
      int h0;
      h0 = hazir_sayisi;
      kelime_gonder(4'b0011, 3'd5, 1'b1);
      testler++;
      if (hazir !== 1'b1 || veri_cikisi !== 4'b1001) begin
         hatalar++;
         $display("FAIL subtract: hazir=%b veri=%b expected 1/1001", hazir, veri_cikisi);
      end
      tick();
      testler++;
      if (hazir_sayisi - h0 != 1) begin
         hatalar++;
         $display("FAIL subtract_pulses: got %0d expected 1", hazir_sayisi - h0);
      end
      $display("[TB] subtract: veri=%b", veri_cikisi);
   endtask

   task automatic test_back_to_back();
      logic [3:0] w1;
      logic [3:0] w2;
      w1 = 4'b0110;
      w2 = 4'b0000;
      for (int t = 1; t <= 10; t++) begin
         if (t <= 4) begin
            secim = 3'd7;
            mod   = 1'b1;
            gecerli_giris = 1'b1;
            bit_girisi = w1[t-1];
         end else if (t <= 8) begin
            secim = 3'd1;
            mod   = 1'b0;
            gecerli_giris = 1'b1;
            bit_girisi = w2[t-5];
         end else begin
            gecerli_giris = 1'b0;
            bit_girisi = 1'b0;
         end
         tick();
         testler++;
         if (hazir !== ((t == 5) || (t == 9))) begin
            hatalar++;
            $display("FAIL b2b_hazir_t%0d: got %b expected %b", t, hazir, (t == 5) || (t == 9));
         end
         if (t == 5) begin
            testler++;
            if (veri_cikisi !== 4'b0100) begin
               hatalar++;
               $display("FAIL b2b_gray: got %b expected 0100", veri_cikisi);
            end
         end
         if (t == 9) begin
            testler++;
            if (veri_cikisi !== 4'b1111) begin
               hatalar++;
               $display("FAIL b2b_not: got %b expected 1111", veri_cikisi);
            end
         end
      end
      $display("[TB] back to back: last veri=%b", veri_cikisi);
   endtask

   task automatic test_gap_ok();
      int e0;
      e0 = hata_sayisi;
      secim = 3'd0;
      mod   = 1'b0;
      bit_ver(1'b1);
      bit_ver(1'b0);
      bos_ver(7);
      bit_ver(1'b1);
      bit_ver(1'b1);
      bos_ver(1);
      testler++;
      if (hazir !== 1'b1 || veri_cikisi !== 4'b1101) begin
         hatalar++;
         $display("FAIL gap_ok: hazir=%b veri=%b expected 1/1101", hazir, veri_cikisi);
      end
      testler++;
      if (hata_sayisi != e0) begin
         hatalar++;
         $display("FAIL gap_ok_hata: %0d pulses expected 0", hata_sayisi - e0);
      end
      $display("[TB] gap 7 tolerated: veri=%b", veri_cikisi);
   endtask

   task automatic test_gap_timeout();
      int h0;
      tick();
      h0 = hazir_sayisi;
      secim = 3'd0;
      mod   = 1'b0;
      bit_ver(1'b1);
      bit_ver(1'b1);
      bos_ver(7);
      testler++;
      if (hata !== 1'b0) begin
         hatalar++;
         $display("FAIL timeout_early: hata=%b expected 0 after 7 idle", hata);
      end
      tick();
      testler++;
      if (hata !== 1'b1 || hazir !== 1'b0 || veri_cikisi !== 4'b1101) begin
         hatalar++;
         $display("FAIL timeout: hata=%b hazir=%b veri=%b expected 1/0/1101", hata, hazir, veri_cikisi);
      end
      tick();
      testler++;
      if (hata !== 1'b0 || hazir_sayisi != h0) begin
         hatalar++;
         $display("FAIL timeout_pulse: hata=%b hazir pulses=%0d expected 0/0", hata, hazir_sayisi - h0);
      end
      kelime_gonder(4'b1010, 3'd3, 1'b0);
      testler++;
      if (hazir !== 1'b1 || veri_cikisi !== 4'b0101) begin
         hatalar++;
         $display("FAIL timeout_fresh: hazir=%b veri=%b expected 1/0101", hazir, veri_cikisi);
      end
      $display("[TB] gap timeout then fresh word: veri=%b", veri_cikisi);
   endtask

   task automatic test_latch();
      secim = 3'd4;
      mod   = 1'b0;
      bit_ver(1'b1);
      secim = 3'd0;
      mod   = 1'b1;
      bit_ver(1'b0);
      bit_ver(1'b0);
      bit_ver(1'b0);
      bos_ver(1);
      testler++;
      if (hazir !== 1'b1 || veri_cikisi !== 4'b1011) begin
         hatalar++;
         $display("FAIL latch: hazir=%b veri=%b expected 1/1011", hazir, veri_cikisi);
      end
      $display("[TB] latch: veri=%b", veri_cikisi);
   endtask

   task automatic test_reset_midword();
      int e0;
      e0 = hata_sayisi;
      secim = 3'd6;
      mod   = 1'b0;
      bit_ver(1'b1);
      bit_ver(1'b1);
      gecerli_giris = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      testler++;
      if (veri_cikisi !== 4'b0000 || hazir !== 1'b0 || hata !== 1'b0) begin
         hatalar++;
         $display("FAIL midreset: veri=%b hazir=%b hata=%b expected 0000/0/0", veri_cikisi, hazir, hata);
      end
      kelime_gonder(4'b0100, 3'd6, 1'b0);
      testler++;
      if (hazir !== 1'b1 || veri_cikisi !== 4'b0001) begin
         hatalar++;
         $display("FAIL midreset_word: hazir=%b veri=%b expected 1/0001", hazir, veri_cikisi);
      end
      testler++;
      if (hata_sayisi != e0) begin
         hatalar++;
         $display("FAIL midreset_hata: %0d pulses expected 0", hata_sayisi - e0);
      end
      $display("[TB] reset mid-word: veri=%b", veri_cikisi);
   endtask

   task automatic test_table();
      logic [2:0] s_t[8] = '{3'd2, 3'd5, 3'd7, 3'd6, 3'd4, 3'd1, 3'd0, 3'd3};
      logic       m_t[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] w_t[8] = '{4'b1101, 4'b0011, 4'b0110, 4'b1101, 4'b0110, 4'b1010, 4'b1001, 4'b1000};
      logic [3:0] e_t[8] = '{4'b1011, 4'b1101, 4'b0101, 4'b0111, 4'b1100, 4'b0101, 4'b1001, 4'b0001};
      for (int i = 0; i < 8; i++) begin
         kelime_gonder(w_t[i], s_t[i], m_t[i]);
         testler++;
         if (hazir !== 1'b1 || veri_cikisi !== e_t[i]) begin
            hatalar++;
            $display("FAIL table_%0d: secim=%0d mod=%b w=%b hazir=%b veri=%b expected 1/%b",
                     i, s_t[i], m_t[i], w_t[i], hazir, veri_cikisi, e_t[i]);
         end
         $display("[TB] table %0d: secim=%0d mod=%b w=%b veri=%b", i, s_t[i], m_t[i], w_t[i], veri_cikisi);
         bos_ver(1);
      end
   endtask

   initial begin
      reset = 1'b1;
      bit_girisi = 1'b0;
      gecerli_giris = 1'b0;
      mod = 1'b0;
      secim = 3'd0;
      test_reset();
      test_rotate_inverse();
      test_subtract();
      test_back_to_back();
      test_gap_ok();
      test_gap_timeout();
      test_latch();
      test_reset_midword();
      test_table();
      $display("[TB] %0d tests run, %0d failed", testler, hatalar);
      $finish;
   end

endmodule
